// File: rtl/lcd_mode_sequencer_if.sv
// Control and status bundle between the PPU control logic and the dot/line scheduler.
// The master drives the LCD enable, LYC, STAT enables and pixel-pipe done flag.
interface lcd_mode_sequencer_if;
    logic       lcd_en;
    logic [7:0] lyc;
    logic [3:0] stat_ie;
    logic       xfer_done;
    logic [8:0] dot;
    logic [7:0] ly;
    logic [1:0] mode;
    logic       oam_scan;
    logic       xfer;
    logic       line_start;
    logic       lyc_match;
    logic       int_stat;
    logic       int_vblank;

    modport master (
        output lcd_en, lyc, stat_ie, xfer_done,
        input  dot, ly, mode, oam_scan, xfer, line_start, lyc_match, int_stat, int_vblank
    );

    modport slave (
        input  lcd_en, lyc, stat_ie, xfer_done,
        output dot, ly, mode, oam_scan, xfer, line_start, lyc_match, int_stat, int_vblank
    );
endinterface

// File: rtl/lcd_mode_sequencer.sv
// Dot/line scheduler for the LCD datapath: dot and line counters, PPU mode FSM,
// pixel-transfer window, LYC compare and STAT/VBlank interrupt generation.
module lcd_mode_sequencer #(
    parameter int unsigned DOTS_PER_LINE   = 456,
    parameter int unsigned LINES_PER_FRAME = 154,
    parameter int unsigned VISIBLE_LINES   = 144,
    parameter int unsigned OAM_DOTS        = 80,
    parameter int unsigned LY_LAST_EARLY   = 4
) (
    input  logic                 clk2,
    input  logic                 nreset_video,
    lcd_mode_sequencer_if.slave  bus
);
    localparam logic [8:0] DOT_LAST  = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] OAM_END   = 9'(OAM_DOTS);
    localparam logic [8:0] LY_EARLY  = 9'(LY_LAST_EARLY);
    localparam logic [7:0] LINE_LAST = 8'(LINES_PER_FRAME - 1);
    localparam logic [7:0] VIS_LINES = 8'(VISIBLE_LINES);

    // Low two bits of the active states are the STAT mode encoding.
    typedef enum logic [2:0] {
        S_HBL  = 3'd0,
        S_VBL  = 3'd1,
        S_OAM  = 3'd2,
        S_XFER = 3'd3,
        S_IDLE = 3'd4
    } state_t;

    state_t     state_q, state_n;
    logic [8:0] dot_q, dot_n;
    logic [7:0] line_q, line_n;
    logic       first_q, first_n;

    logic [7:0] ly_q, ly_n;
    logic [1:0] mode_q, mode_n;
    logic       oam_q, oam_n;
    logic       xfer_q, xfer_n;
    logic       ls_q, ls_n;
    logic       lycm_q, lycm_n;
    logic       ints_q, ints_n;
    logic       intv_q, intv_n;
    logic       stat_q, stat_n;
    logic       active;

    always_ff @(posedge clk2 or negedge nreset_video) begin
        if (!nreset_video) begin
            state_q <= S_IDLE;
            dot_q   <= '0;
            line_q  <= '0;
            first_q <= 1'b1;
            ly_q    <= '0;
            mode_q  <= '0;
            oam_q   <= 1'b0;
            xfer_q  <= 1'b0;
            ls_q    <= 1'b0;
            lycm_q  <= 1'b0;
            ints_q  <= 1'b0;
            intv_q  <= 1'b0;
            stat_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            dot_q   <= dot_n;
            line_q  <= line_n;
            first_q <= first_n;
            ly_q    <= ly_n;
            mode_q  <= mode_n;
            oam_q   <= oam_n;
            xfer_q  <= xfer_n;
            ls_q    <= ls_n;
            lycm_q  <= lycm_n;
            ints_q  <= ints_n;
            intv_q  <= intv_n;
            stat_q  <= stat_n;
        end
    end

    // The line wrap outranks xfer_done, so a done at the last dot cannot add an HBL step.
    always_comb begin
        state_n = state_q;
        dot_n   = dot_q;
        line_n  = line_q;
        first_n = first_q;
        if (!bus.lcd_en) begin
            state_n = S_IDLE;
            dot_n   = '0;
            line_n  = '0;
            first_n = 1'b1;
        end else if (state_q == S_IDLE) begin
            state_n = S_OAM;
            dot_n   = '0;
            line_n  = '0;
            first_n = 1'b1;
        end else if (dot_q == DOT_LAST) begin
            dot_n   = '0;
            line_n  = (line_q == LINE_LAST) ? '0 : line_q + 8'd1;
            first_n = 1'b0;
            state_n = (line_n < VIS_LINES) ? S_OAM : S_VBL;
        end else begin
            dot_n = dot_q + 9'd1;
            case (state_q)
                S_OAM:   if (dot_n == OAM_END) state_n = S_XFER;
                S_XFER:  if (bus.xfer_done)    state_n = S_HBL;
                default: ;
            endcase
        end
    end

    // Outputs are computed for the upcoming dot and registered alongside the state.
    always_comb begin
        active = (state_n != S_IDLE);
        ly_n   = '0;
        mode_n = '0;
        if (active) begin
            ly_n   = (line_n == LINE_LAST && dot_n >= LY_EARLY) ? '0 : line_n;
            mode_n = (state_n == S_OAM && first_n) ? 2'd0 : state_n[1:0];
        end
        oam_n  = active && (dot_n < OAM_END) && (line_n < VIS_LINES);
        xfer_n = (state_n == S_XFER);
        ls_n   = active && (dot_n == '0);
        lycm_n = active && (state_q != S_IDLE) && (ly_q == bus.lyc);
        stat_n = active && (((mode_n == 2'd0) && bus.stat_ie[0]) ||
                            ((mode_n == 2'd1) && bus.stat_ie[1]) ||
                            ((mode_n == 2'd2) && bus.stat_ie[2]) ||
                            (lycm_n && bus.stat_ie[3]) ||
                            ((line_n == VIS_LINES) && (dot_n == '0) && bus.stat_ie[2]));
        ints_n = stat_n && !stat_q;
        intv_n = (state_n == S_VBL) && (state_q != S_VBL);
    end

    assign bus.dot        = dot_q;
    assign bus.ly         = ly_q;
    assign bus.mode       = mode_q;
    assign bus.oam_scan   = oam_q;
    assign bus.xfer       = xfer_q;
    assign bus.line_start = ls_q;
    assign bus.lyc_match  = lycm_q;
    assign bus.int_stat   = ints_q;
    assign bus.int_vblank = intv_q;
endmodule

// File: tb/tb_lcd_mode_sequencer.sv
// Self-checking bench for lcd_mode_sequencer: randomized pixel-pipe done timing
// compared every cycle against a position-based reference model.
module tb_lcd_mode_sequencer;
    localparam int DPL    = 456;
    localparam int LPF    = 154;
    localparam int VIS    = 144;
    localparam int OAMD   = 80;
    localparam int FRAME  = DPL * LPF;

    logic clk2 = 1'b0;
    logic nreset_video;
    lcd_mode_sequencer_if bus();

    lcd_mode_sequencer dut (
        .clk2         (clk2),
        .nreset_video (nreset_video),
        .bus          (bus)
    );

    always #5 clk2 = ~clk2;

    int passed = 0;
    int total  = 0;

    // Reference model state: position derived from cycles since enable.
    bit         m_run = 1'b0;
    bit         m_first = 1'b1;
    int         m_t = 0;
    int         m_line = 0;
    int         m_dot = 0;
    int         m_done_at = -1;
    int         m_d = 1000;
    int         m_junk = 1000;
    int         m_stuck_line = -1;
    logic [7:0] m_ly = '0;
    logic [1:0] m_mode = '0;
    bit         m_oam, m_xfer, m_ls, m_lycm, m_ints, m_intv, m_stat;
    logic [24:0] exp_vec, obs_vec;

    function automatic logic [24:0] pack_obs();
        return {bus.dot, bus.ly, bus.mode, bus.oam_scan, bus.xfer, bus.line_start,
                bus.lyc_match, bus.int_stat, bus.int_vblank};
    endfunction

    function automatic int pick_d(int line);
        if (line == m_stuck_line) return 1000;
        if (line == 2 || line == 10) return 252;
        if (line == 9) return 300;
        if (line == 5) return DPL - 1;
        return int'($urandom_range(OAMD, DPL - 1));
    endfunction

    task automatic model_idle();
        m_run = 0; m_dot = 0; m_line = 0; m_mode = '0; m_ly = '0; m_first = 1;
        m_oam = 0; m_xfer = 0; m_ls = 0; m_lycm = 0; m_ints = 0; m_intv = 0; m_stat = 0;
        m_d = 1000; m_junk = 1000; m_done_at = -1;
    endtask

    task automatic tick();
        logic [7:0] lyc_s, prev_ly;
        logic [3:0] ie_s;
        logic       en_s;
        bit         prev_run, st;
        bus.xfer_done = m_run && (m_dot == m_d || m_dot == m_junk);
        if (m_run && m_mode == 2'd3 && bus.xfer_done) m_done_at = m_dot;
        lyc_s = bus.lyc; ie_s = bus.stat_ie; en_s = bus.lcd_en;
        prev_run = m_run; prev_ly = m_ly;
        @(posedge clk2);
        #1;
        if (!en_s) begin
            model_idle();
        end else begin
            if (!m_run) begin m_run = 1; m_t = 0; end
            else m_t++;
            m_dot   = m_t % DPL;
            m_line  = (m_t / DPL) % LPF;
            m_first = (m_t < DPL);
            if (m_dot == 0) begin
                m_done_at = -1;
                m_d = pick_d(m_line);
                m_junk = (m_line >= VIS) ? int'($urandom_range(0, DPL - 1))
                                         : int'($urandom_range(0, OAMD - 1));
            end
            if (m_line >= VIS)                           m_mode = 2'd1;
            else if (m_dot < OAMD)                       m_mode = m_first ? 2'd0 : 2'd2;
            else if (m_done_at >= 0 && m_dot > m_done_at) m_mode = 2'd0;
            else                                         m_mode = 2'd3;
            m_ly   = (m_line == LPF - 1 && m_dot >= 4) ? 8'd0 : 8'(m_line);
            m_oam  = (m_line < VIS) && (m_dot < OAMD);
            m_xfer = (m_mode == 2'd3);
            m_ls   = (m_dot == 0);
            m_lycm = prev_run && (prev_ly == lyc_s);
            m_intv = (m_line == VIS) && (m_dot == 0);
            st = (m_mode == 2'd0 && ie_s[0]) || (m_mode == 2'd1 && ie_s[1]) ||
                 (m_mode == 2'd2 && ie_s[2]) || (m_lycm && ie_s[3]) ||
                 (m_line == VIS && m_dot == 0 && ie_s[2]);
            m_ints = st && !m_stat;
            m_stat = st;
        end
        exp_vec = {9'(m_dot), m_ly, m_mode, m_oam, m_xfer, m_ls, m_lycm, m_ints, m_intv};
        obs_vec = pack_obs();
    endtask

    task automatic test_reset();
        bus.lcd_en = 0; bus.lyc = '0; bus.stat_ie = '0; bus.xfer_done = 0;
        nreset_video = 0;
        model_idle();
        repeat (3) @(posedge clk2);
        #1;
        total++;
        if (pack_obs() !== '0) $display("FAIL reset_outputs got=%h exp=0", pack_obs());
        else passed++;
        nreset_video = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (obs_vec !== exp_vec) $display("FAIL idle_hold got=%h exp=%h", obs_vec, exp_vec);
            else passed++;
        end
    endtask

    task automatic test_enable_drop();
        int guard = 0;
        int cnt10 = 0;
        bus.stat_ie = 4'b0101; bus.lyc = 8'd7; m_stuck_line = 12;
        bus.lcd_en = 1;
        while (!(m_run && m_line == 50 && m_dot == 100) && guard < 30000) begin
            tick();
            guard++;
            total++;
            if (obs_vec !== exp_vec)
                $display("FAIL run_line t=%0d line=%0d dot=%0d got=%h exp=%h", m_t, m_line, m_dot, obs_vec, exp_vec);
            else passed++;
            if (m_line == 10 && bus.int_stat === 1'b1) cnt10++;
        end
        total++;
        if (guard >= 30000) $display("FAIL reach_line50 got=timeout exp=line50");
        else passed++;
        total++;
        if (cnt10 !== 1) $display("FAIL stat_line10_pulses got=%0d exp=1", cnt10);
        else passed++;
        bus.lcd_en = 0;
        tick();
        total++;
        if (obs_vec !== '0) $display("FAIL disable_outputs got=%h exp=0", obs_vec);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (obs_vec !== exp_vec) $display("FAIL disabled_idle got=%h exp=%h", obs_vec, exp_vec);
            else passed++;
        end
    endtask

    task automatic test_reenable();
        bus.lcd_en = 1;
        for (int i = 0; i < 82; i++) begin
            tick();
            total++;
            if (obs_vec !== exp_vec)
                $display("FAIL reenable dot=%0d got=%h exp=%h", m_dot, obs_vec, exp_vec);
            else passed++;
            if (m_dot == 79) begin
                total++;
                if ({bus.mode, bus.oam_scan} !== 3'b001)
                    $display("FAIL first_line_oam mode_oam=%b exp=001", {bus.mode, bus.oam_scan});
                else passed++;
            end
            if (m_dot == 80) begin
                total++;
                if (bus.mode !== 2'd3) $display("FAIL first_line_xfer mode=%0d exp=3", bus.mode);
                else passed++;
            end
        end
    endtask

    task automatic test_frame();
        int guard = 0;
        int cnt_vb = 0;
        int cnt_lyc = 0;
        bus.stat_ie = 4'b1000; bus.lyc = 8'd153; m_stuck_line = VIS - 1;
        while (m_t < FRAME + DPL + 10 && guard < 80000) begin
            tick();
            guard++;
            total++;
            if (obs_vec !== exp_vec)
                $display("FAIL frame t=%0d line=%0d dot=%0d got=%h exp=%h", m_t, m_line, m_dot, obs_vec, exp_vec);
            else passed++;
            if (m_t < FRAME && bus.int_vblank === 1'b1) cnt_vb++;
            if ((m_line == LPF - 1 || (m_t >= FRAME && m_line == 0)) && bus.int_stat === 1'b1) cnt_lyc++;
            if (m_t < FRAME && m_line == LPF - 1 && m_dot == 3) begin
                total++;
                if (bus.ly !== 8'd153) $display("FAIL ly_last_early got=%0d exp=153", bus.ly);
                else passed++;
            end
            if (m_t < FRAME && m_line == LPF - 1 && m_dot == 4) begin
                total++;
                if (bus.ly !== 8'd0) $display("FAIL ly_last_zero got=%0d exp=0", bus.ly);
                else passed++;
                bus.lyc = 8'd0;
            end
            if (m_t == FRAME) begin
                total++;
                if ({bus.dot, bus.ly, bus.line_start, bus.mode} !== {9'd0, 8'd0, 1'b1, 2'd2})
                    $display("FAIL frame_period dot=%0d ly=%0d ls=%b mode=%0d exp=0,0,1,2",
                             bus.dot, bus.ly, bus.line_start, bus.mode);
                else passed++;
            end
        end
        total++;
        if (guard >= 80000) $display("FAIL frame_budget got=timeout exp=done");
        else passed++;
        total++;
        if (cnt_vb !== 1) $display("FAIL vblank_count got=%0d exp=1", cnt_vb);
        else passed++;
        total++;
        if (cnt_lyc !== 1) $display("FAIL lyc_stat_pulses got=%0d exp=1", cnt_lyc);
        else passed++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (obs_vec !== exp_vec) $display("FAIL pre_async got=%h exp=%h", obs_vec, exp_vec);
            else passed++;
        end
        #2;
        nreset_video = 0;
        #1;
        total++;
        if (pack_obs() !== '0) $display("FAIL async_reset got=%h exp=0", pack_obs());
        else passed++;
        model_idle();
        nreset_video = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (obs_vec !== exp_vec) $display("FAIL post_async got=%h exp=%h", obs_vec, exp_vec);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_enable_drop();
        test_reenable();
        test_frame();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
